// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, write-allocate data cache with one-word lines.
// Loads hit combinationally; misses fill from word memory, stores write through.
module dcache_ctrl #(
  parameter int XLEN        = 32,
  parameter int SETS        = 256,
  parameter int MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_re,
  input  logic            cpu_we,
  input  logic [XLEN-1:0] cpu_addr,
  input  logic [XLEN-1:0] cpu_wd,
  input  logic [3:0]      cpu_be,
  output logic [XLEN-1:0] cpu_rd,
  output logic            stall,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd,
  output logic [1:0]      dbg_state_o
);

  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS   = XLEN - INDEX_BITS - 2;
  localparam int CNT_BITS   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(MEM_LATENCY - 1);

  // dbg_state_o encoding: 0 = IDLE, 1 = FILL, 2 = WRITE
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e                state_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic [XLEN-3:0]       req_addr_q;
  logic [SETS-1:0]       valid_q;
  logic [TAG_BITS-1:0]   tag_q  [SETS];
  logic [XLEN-1:0]       data_q [SETS];

  logic [INDEX_BITS-1:0] cpu_idx;
  logic [TAG_BITS-1:0]   cpu_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  req_any;
  logic                  is_store;
  logic                  hit;
  logic                  fill_done;
  logic                  merge_en;
  logic [XLEN-1:0]       line_word;
  logic [XLEN-1:0]       merged;
  logic                  unused_addr_bits;

  assign cpu_idx   = cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag   = cpu_addr[XLEN-1:INDEX_BITS+2];
  assign req_idx   = req_addr_q[INDEX_BITS-1:0];
  assign req_tag   = req_addr_q[XLEN-3:INDEX_BITS];
  assign req_any   = cpu_re | cpu_we;
  assign is_store  = cpu_we;
  assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign line_word = data_q[cpu_idx];
  assign fill_done = (state_q == S_FILL) && (cnt_q == CNT_LAST);
  assign merge_en  = (state_q == S_IDLE) && is_store && hit;
  assign unused_addr_bits = ^cpu_addr[1:0];

  always_comb begin
    merged = line_word;
    for (int b = 0; b < 4; b++) begin
      if (cpu_be[b]) merged[8*b +: 8] = cpu_wd[8*b +: 8];
    end
  end

  // Outputs: stall depends on the live hit check in IDLE; mem_we on state only.
  always_comb begin
    stall  = 1'b0;
    mem_we = 1'b0;
    mem_a  = {cpu_addr[XLEN-1:2], 2'b00};
    case (state_q)
      S_IDLE:  stall = req_any && (!hit || is_store);
      S_FILL: begin
        stall = 1'b1;
        mem_a = {req_addr_q, 2'b00};
      end
      S_WRITE: begin
        mem_we = 1'b1;
        mem_a  = {req_addr_q, 2'b00};
      end
      default: stall = 1'b0;
    endcase
  end

  assign mem_wd      = data_q[req_idx];
  assign cpu_rd      = line_word;
  assign dbg_state_o = state_q;

  // Line storage; a reset in the fill's last cycle leaves the line untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_done) begin
        data_q[req_idx] <= mem_rd;
        tag_q[req_idx]  <= req_tag;
      end else if (merge_en) begin
        data_q[cpu_idx] <= merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      req_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_any && !hit) begin
            req_addr_q <= cpu_addr[XLEN-1:2];
            cnt_q      <= '0;
            state_q    <= S_FILL;
          end else if (req_any && is_store) begin
            req_addr_q <= cpu_addr[XLEN-1:2];
            state_q    <= S_WRITE;
          end
        end
        S_FILL: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            valid_q[req_idx] <= 1'b1;
            state_q          <= S_IDLE;
          end
        end
        S_WRITE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: two instances (memory latency 1 and 3) checked against
// a transaction-level cache/memory model, plus directed reset scenarios.
module tb_dcache_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic        cpu_re   [2];
  logic        cpu_we   [2];
  logic [31:0] cpu_addr [2];
  logic [31:0] cpu_wd   [2];
  logic [3:0]  cpu_be   [2];
  logic [31:0] cpu_rd   [2];
  logic        stall    [2];
  logic        mem_we   [2];
  logic [31:0] mem_a    [2];
  logic [31:0] mem_wd   [2];
  logic [31:0] mem_rd   [2];
  logic [1:0]  dbg_state[2];

  dcache_ctrl #(.XLEN(32), .SETS(256), .MEM_LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .cpu_re(cpu_re[0]), .cpu_we(cpu_we[0]),
    .cpu_addr(cpu_addr[0]), .cpu_wd(cpu_wd[0]), .cpu_be(cpu_be[0]),
    .cpu_rd(cpu_rd[0]), .stall(stall[0]), .mem_we(mem_we[0]), .mem_a(mem_a[0]),
    .mem_wd(mem_wd[0]), .mem_rd(mem_rd[0]), .dbg_state_o(dbg_state[0])
  );

  dcache_ctrl #(.XLEN(32), .SETS(256), .MEM_LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .cpu_re(cpu_re[1]), .cpu_we(cpu_we[1]),
    .cpu_addr(cpu_addr[1]), .cpu_wd(cpu_wd[1]), .cpu_be(cpu_be[1]),
    .cpu_rd(cpu_rd[1]), .stall(stall[1]), .mem_we(mem_we[1]), .mem_a(mem_a[1]),
    .mem_wd(mem_wd[1]), .mem_rd(mem_rd[1]), .dbg_state_o(dbg_state[1])
  );

  // Environment memory: 16 KB window from 0x10000, aliased on addr[13:2].
  logic [31:0] env_mem [2][4096];
  assign mem_rd[0] = env_mem[0][mem_a[0][13:2]];
  assign mem_rd[1] = env_mem[1][mem_a[1][13:2]];

  // Reference model: cache contents and memory at transaction level.
  bit          m_valid [2][256];
  logic [21:0] m_tag   [2][256];
  logic [31:0] m_data  [2][256];
  logic [31:0] ref_mem [2][4096];

  bit          act[2], done[2], manual[2];
  int          nst[2], nwr[2], exp_stall[2];
  logic        exp_store[2];
  logic [31:0] exp_addr[2], exp_rd[2], exp_wd[2];
  int          last_stall[2], last_nwr[2];
  logic [31:0] last_rd[2], last_wd[2], last_ma[2];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input int u, input int i);
    if (i == 0) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ (32'(u) << 24);
  endfunction

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act_v, exp_v, $time);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 4096; i++) env_mem[u][i] = init_word(u, i);
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++)
        if (mem_we[u] === 1'b1) env_mem[u][mem_a[u][13:2]] = mem_wd[u];
    end
  end

  // Compare process: every cycle, either an active request or an idle cache.
  initial begin
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (rst[u] || manual[u]) continue;
        if (act[u]) begin
          chk($sformatf("mem_a_u%0d", u), mem_a[u], exp_addr[u]);
          if (mem_we[u] === 1'b1) nwr[u]++;
          if (stall[u] === 1'b1) begin
            nst[u]++;
            chk($sformatf("mem_we_stall_u%0d", u), {31'b0, mem_we[u]}, 32'd0);
          end else begin
            chk($sformatf("stall_cycles_u%0d", u), nst[u], exp_stall[u]);
            if (exp_store[u]) begin
              chk($sformatf("mem_we_store_u%0d", u), {31'b0, mem_we[u]}, 32'd1);
              chk($sformatf("mem_wd_u%0d", u), mem_wd[u], exp_wd[u]);
            end else begin
              chk($sformatf("mem_we_load_u%0d", u), {31'b0, mem_we[u]}, 32'd0);
              chk($sformatf("cpu_rd_u%0d", u), cpu_rd[u], exp_rd[u]);
            end
            last_stall[u] = nst[u];
            last_nwr[u]   = nwr[u];
            last_rd[u]    = cpu_rd[u];
            last_wd[u]    = mem_wd[u];
            last_ma[u]    = mem_a[u];
            act[u]  = 1'b0;
            done[u] = 1'b1;
          end
        end else begin
          chk($sformatf("idle_stall_u%0d", u), {31'b0, stall[u]}, 32'd0);
          chk($sformatf("idle_mem_we_u%0d", u), {31'b0, mem_we[u]}, 32'd0);
          chk($sformatf("idle_mem_a_u%0d", u), mem_a[u], {cpu_addr[u][31:2], 2'b00});
        end
      end
    end
  end

  task automatic model_flush(input int u);
    for (int i = 0; i < 256; i++) m_valid[u][i] = 1'b0;
  endtask

  task automatic do_req(input int u, input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
    int          w, ix, lat;
    logic [21:0] tg;
    logic        hit;
    logic [31:0] m;
    w   = int'(addr[13:2]);
    ix  = int'(addr[9:2]);
    tg  = addr[31:10];
    lat = (u == 0) ? 1 : 3;
    hit = m_valid[u][ix] && (m_tag[u][ix] == tg);
    exp_stall[u] = 0;
    if (!hit) begin
      exp_stall[u] = lat + 1;
      m_valid[u][ix] = 1'b1;
      m_tag[u][ix]   = tg;
      m_data[u][ix]  = ref_mem[u][w];
    end
    if (we) begin
      m = m_data[u][ix];
      for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wd[8*b +: 8];
      m_data[u][ix] = m;
      ref_mem[u][w] = m;
      exp_stall[u]  = exp_stall[u] + 1;
      exp_wd[u]     = m;
    end
    exp_rd[u]    = m_data[u][ix];
    exp_store[u] = we;
    exp_addr[u]  = {addr[31:2], 2'b00};
    @(posedge clk); #1;
    cpu_re[u] = re; cpu_we[u] = we; cpu_addr[u] = addr; cpu_wd[u] = wd; cpu_be[u] = be;
    nst[u] = 0; nwr[u] = 0; done[u] = 1'b0; act[u] = 1'b1;
    for (int c = 0; c < 64 && !done[u]; c++) begin
      @(negedge clk); #1;
    end
    if (!done[u]) begin
      checks++;
      errors++;
      $display("FAIL timeout_u%0d actual=no_retire required=retire_within_64_cycles", u);
      act[u] = 1'b0;
    end
  endtask

  task automatic idle(input int u, input int n);
    @(posedge clk); #1;
    cpu_re[u] = 1'b0; cpu_we[u] = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic reset_in_fill(input int u, input logic [31:0] addr);
    manual[u] = 1'b1;
    @(posedge clk); #1;
    cpu_re[u] = 1'b1; cpu_we[u] = 1'b0; cpu_addr[u] = addr;
    @(negedge clk);
    chk("rf_miss_stall", {31'b0, stall[u]}, 32'd1);
    @(posedge clk); #1;
    rst[u] = 1'b1;
    @(negedge clk);
    chk("rf_in_fill", {30'b0, dbg_state[u]}, 32'd1);
    chk("rf_fill_mem_we", {31'b0, mem_we[u]}, 32'd0);
    @(posedge clk); #1;
    rst[u] = 1'b0; cpu_re[u] = 1'b0;
    @(negedge clk);
    chk("rf_state_idle", {30'b0, dbg_state[u]}, 32'd0);
    chk("rf_mem_we", {31'b0, mem_we[u]}, 32'd0);
    chk("rf_stall", {31'b0, stall[u]}, 32'd0);
    model_flush(u);
    manual[u] = 1'b0;
  endtask

  task automatic reset_in_write(input int u, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] be);
    logic [31:0] m;
    m = m_data[u][int'(addr[9:2])];
    for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wd[8*b +: 8];
    manual[u] = 1'b1;
    @(posedge clk); #1;
    cpu_re[u] = 1'b0; cpu_we[u] = 1'b1; cpu_addr[u] = addr; cpu_wd[u] = wd; cpu_be[u] = be;
    @(negedge clk);
    chk("rw_hit_stall", {31'b0, stall[u]}, 32'd1);
    @(posedge clk); #1;
    rst[u] = 1'b1;
    @(negedge clk);
    chk("rw_mem_we", {31'b0, mem_we[u]}, 32'd1);
    chk("rw_mem_wd", mem_wd[u], m);
    chk("rw_stall", {31'b0, stall[u]}, 32'd0);
    @(posedge clk); #1;
    rst[u] = 1'b0; cpu_we[u] = 1'b0;
    @(negedge clk);
    chk("rw_state_idle", {30'b0, dbg_state[u]}, 32'd0);
    chk("rw_mem_we_after", {31'b0, mem_we[u]}, 32'd0);
    ref_mem[u][int'(addr[13:2])] = m;
    model_flush(u);
    manual[u] = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; cpu_re[u] = 1'b0; cpu_we[u] = 1'b0;
      cpu_addr[u] = '0; cpu_wd[u] = '0; cpu_be[u] = '0;
      act[u] = 1'b0; done[u] = 1'b0; manual[u] = 1'b0;
      model_flush(u);
      for (int i = 0; i < 4096; i++) ref_mem[u][i] = init_word(u, i);
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset_state_u%0d", u), {30'b0, dbg_state[u]}, 32'd0);
      chk($sformatf("reset_stall_u%0d", u), {31'b0, stall[u]}, 32'd0);
      chk($sformatf("reset_mem_we_u%0d", u), {31'b0, mem_we[u]}, 32'd0);
    end

    // Cold load miss, latency 1
    do_req(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0);
    chk("t1_stall", last_stall[0], 32'd2);
    chk("t1_rd", last_rd[0], 32'hDEADBEEF);
    chk("t1_nwr", last_nwr[0], 32'd0);
    chk("t1_ma", last_ma[0], 32'h0001_0000);

    // Sub-word store hit
    do_req(0, 1'b0, 1'b1, 32'h0001_0000, 32'h0000_AB00, 4'b0010);
    chk("t2_stall", last_stall[0], 32'd1);
    chk("t2_wd", last_wd[0], 32'hDEADABEF);
    chk("t2_ma", last_ma[0], 32'h0001_0000);
    chk("t2_nwr", last_nwr[0], 32'd1);
    do_req(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0);
    chk("t2_load_stall", last_stall[0], 32'd0);
    chk("t2_load_rd", last_rd[0], 32'hDEADABEF);

    // Unaligned load address hits the same line
    do_req(0, 1'b1, 1'b0, 32'h0001_0003, 32'h0, 4'h0);
    chk("t6_stall", last_stall[0], 32'd0);
    chk("t6_rd", last_rd[0], 32'hDEADABEF);
    chk("t6_ma", last_ma[0], 32'h0001_0000);

    // Reset during fill; everything cached before must miss afterwards
    do_req(0, 1'b1, 1'b0, 32'h0001_0008, 32'h0, 4'h0);
    do_req(0, 1'b1, 1'b0, 32'h0001_0400, 32'h0, 4'h0);
    reset_in_fill(0, 32'h0001_0000);
    do_req(0, 1'b1, 1'b0, 32'h0001_0008, 32'h0, 4'h0);
    chk("t5_old_line_miss", last_stall[0], 32'd2);

    // Conflict misses on one index
    do_req(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0);
    chk("t3_a_stall", last_stall[0], 32'd2);
    do_req(0, 1'b1, 1'b0, 32'h0001_0400, 32'h0, 4'h0);
    chk("t3_b_stall", last_stall[0], 32'd2);
    do_req(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0);
    chk("t3_c_stall", last_stall[0], 32'd2);
    chk("t3_c_rd", last_rd[0], 32'hDEADABEF);

    // Reset during write-through: the write still lands, the line is dropped
    reset_in_write(0, 32'h0001_0000, 32'hAA00_0000, 4'b1000);
    do_req(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0);
    chk("rw_reload_stall", last_stall[0], 32'd2);
    chk("rw_reload_rd", last_rd[0], 32'hAAADABEF);

    // Store miss with latency 3
    do_req(1, 1'b0, 1'b1, 32'h0001_0008, 32'h1234_5678, 4'hF);
    chk("t4_stall", last_stall[1], 32'd5);
    chk("t4_nwr", last_nwr[1], 32'd1);
    chk("t4_wd", last_wd[1], 32'h1234_5678);
    do_req(1, 1'b1, 1'b0, 32'h0001_0008, 32'h0, 4'h0);
    chk("t4_load_stall", last_stall[1], 32'd0);
    chk("t4_load_rd", last_rd[1], 32'h1234_5678);

    // Random traffic on both instances
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 250; n++) begin
        logic [31:0] a;
        int          op;
        a  = 32'h0001_0000 | (32'($urandom_range(0, 3)) << 10) |
             (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        op = $urandom_range(0, 3);
        do_req(u, op != 2, op >= 2, a, $urandom, 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 4) == 0) idle(u, $urandom_range(1, 3));
      end
      idle(u, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
